// File: rtl/a09_pkg.sv
// Shared definitions for the ALU result stage.
//   - Flag bit positions within a flag vector: [0]=Z, [1]=C, [2]=N, [3]=V.
//   - Default data and flag widths.
//   - Occupancy encoding of the two-entry result buffer.
package a09_pkg;

  localparam int unsigned FLAG_Z = 0;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_N = 2;
  localparam int unsigned FLAG_V = 3;

  localparam int unsigned FLAG_WIDTH = 4;
  localparam int unsigned DATA_WIDTH = 16;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    TWO   = 2'b10
  } buf_state_t;

endpackage

// File: rtl/skid_buffer2.sv
// Generic two-entry valid/ready buffer.
// The primary entry drives the outputs; the skid entry holds one
// overflow item so the upstream ready can be driven purely from state.
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   in_valid/in_ready    upstream handshake (in_ready depends only on state)
//   in_data              upstream payload
//   out_valid/out_ready  downstream handshake
//   out_data             oldest buffered payload
module skid_buffer2
  import a09_pkg::*;
#(
  parameter int unsigned Width = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [Width-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [Width-1:0] out_data
);

  buf_state_t       state, state_nxt;
  logic [Width-1:0] prim_q, prim_nxt;
  logic [Width-1:0] skid_q, skid_nxt;
  logic             accept, drain;

  // Both handshake outputs are decoded straight from the state flop, so
  // there is no combinational path from out_ready to in_ready.
  assign in_ready  = (state != TWO);
  assign out_valid = (state != EMPTY);
  assign out_data  = prim_q;

  assign accept = in_valid & in_ready;
  assign drain  = out_valid & out_ready;

  always_comb begin
    state_nxt = state;
    prim_nxt  = prim_q;
    skid_nxt  = skid_q;
    unique case (state)
      EMPTY: begin
        if (accept) begin
          prim_nxt  = in_data;
          state_nxt = ONE;
        end
      end
      ONE: begin
        if (accept && drain) begin
          prim_nxt = in_data;
        end else if (accept) begin
          skid_nxt  = in_data;
          state_nxt = TWO;
        end else if (drain) begin
          state_nxt = EMPTY;
        end
      end
      TWO: begin
        if (drain) begin
          prim_nxt  = skid_q;
          state_nxt = ONE;
        end
      end
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= EMPTY;
      prim_q <= '0;
      skid_q <= '0;
    end else begin
      state  <= state_nxt;
      prim_q <= prim_nxt;
      skid_q <= skid_nxt;
    end
  end

endmodule

// File: rtl/alu_result_stage.sv
// Registered stage downstream of the ALU.
// Captures Y/OFlags through a valid/ready handshake into a two-entry
// buffer feeding writeback, and owns the architectural status-flag
// register that feeds back into the ALU's IFlags.
// Ports:
//   Clock, Reset           clock, asynchronous active-high reset
//   InValid, InReady       ALU-side handshake
//   Y, OFlags              ALU result and flags
//   FlagMask               per-bit status update enable on transfer
//   FlagsLoad, FlagsIn     direct status register write (wins over FlagMask)
//   StatusFlags            status register, to ALU IFlags
//   OutValid, OutReady     writeback-side handshake
//   Result, ResultFlags    oldest buffered result and its captured flags
module alu_result_stage
  import a09_pkg::*;
#(
  parameter int unsigned DataWidth = DATA_WIDTH,
  parameter int unsigned FlagWidth = FLAG_WIDTH
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic                 InValid,
  output logic                 InReady,
  input  logic [DataWidth-1:0] Y,
  input  logic [FlagWidth-1:0] OFlags,
  input  logic [FlagWidth-1:0] FlagMask,
  input  logic                 FlagsLoad,
  input  logic [FlagWidth-1:0] FlagsIn,
  output logic [FlagWidth-1:0] StatusFlags,
  output logic                 OutValid,
  input  logic                 OutReady,
  output logic [DataWidth-1:0] Result,
  output logic [FlagWidth-1:0] ResultFlags
);

  localparam int unsigned PayloadWidth = DataWidth + FlagWidth;

  logic [PayloadWidth-1:0] in_payload, out_payload;
  logic [FlagWidth-1:0]    status_q;
  logic                    accept;

  assign in_payload = {Y, OFlags};

  skid_buffer2 #(
    .Width(PayloadWidth)
  ) u_buf (
    .clk      (Clock),
    .rst      (Reset),
    .in_valid (InValid),
    .in_ready (InReady),
    .in_data  (in_payload),
    .out_valid(OutValid),
    .out_ready(OutReady),
    .out_data (out_payload)
  );

  assign Result      = out_payload[PayloadWidth-1:FlagWidth];
  assign ResultFlags = out_payload[FlagWidth-1:0];

  // Flags update at accept time, independent of writeback backpressure,
  // so the ALU's next operation sees them one cycle after transfer.
  assign accept = InValid & InReady;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      status_q <= '0;
    end else if (FlagsLoad) begin
      status_q <= FlagsIn;
    end else if (accept) begin
      status_q <= (status_q & ~FlagMask) | (OFlags & FlagMask);
    end
  end

  assign StatusFlags = status_q;

endmodule

// File: tb/tb_alu_result_stage.sv
module tb_alu_result_stage;

  localparam int unsigned DW = 16;
  localparam int unsigned FW = 4;

  logic          Clock = 1'b0;
  logic          Reset;
  logic          InValid;
  logic          InReady;
  logic [DW-1:0] Y;
  logic [FW-1:0] OFlags;
  logic [FW-1:0] FlagMask;
  logic          FlagsLoad;
  logic [FW-1:0] FlagsIn;
  logic [FW-1:0] StatusFlags;
  logic          OutValid;
  logic          OutReady;
  logic [DW-1:0] Result;
  logic [FW-1:0] ResultFlags;

  alu_result_stage #(
    .DataWidth(DW),
    .FlagWidth(FW)
  ) dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .InValid    (InValid),
    .InReady    (InReady),
    .Y          (Y),
    .OFlags     (OFlags),
    .FlagMask   (FlagMask),
    .FlagsLoad  (FlagsLoad),
    .FlagsIn    (FlagsIn),
    .StatusFlags(StatusFlags),
    .OutValid   (OutValid),
    .OutReady   (OutReady),
    .Result     (Result),
    .ResultFlags(ResultFlags)
  );

  always #5 Clock = ~Clock;

  int unsigned     n_cmp = 0;
  int unsigned     n_bad = 0;
  logic [DW+FW-1:0] sb_q[$];
  logic [FW-1:0]   exp_status;
  int unsigned     n_drained;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Called at a negedge with inputs already driven; checks outputs
  // against the model, advances the model across one rising edge.
  task automatic cycle(output bit acc);
    logic [DW+FW-1:0] e;
    bit               drn;
    #1;
    check("in_ready",  {31'b0, InReady},  {31'b0, (sb_q.size() < 2)});
    check("out_valid", {31'b0, OutValid}, {31'b0, (sb_q.size() != 0)});
    check("status",    {28'b0, StatusFlags}, {28'b0, exp_status});
    drn = (sb_q.size() != 0) && OutReady;
    acc = InValid && (sb_q.size() < 2);
    if (drn) begin
      e = sb_q.pop_front();
      check("result",       {16'b0, Result},      {16'b0, e[DW+FW-1:FW]});
      check("result_flags", {28'b0, ResultFlags}, {28'b0, e[FW-1:0]});
      n_drained++;
    end
    if (acc) sb_q.push_back({Y, OFlags});
    if (FlagsLoad) exp_status = FlagsIn;
    else if (acc)  exp_status = (exp_status & ~FlagMask) | (OFlags & FlagMask);
    @(posedge Clock);
    @(negedge Clock);
  endtask

  task automatic idle_inputs();
    InValid   = 1'b0;
    FlagsLoad = 1'b0;
    FlagsIn   = '0;
    FlagMask  = '0;
  endtask

  initial begin
    bit acc;
    Reset = 1'b1;
    idle_inputs();
    Y = '0; OFlags = '0; OutReady = 1'b0;
    exp_status = '0;
    n_drained = 0;
    @(negedge Clock);
    @(negedge Clock);
    Reset = 1'b0;
    cycle(acc);

    // Single transfer, full mask
    InValid = 1'b1; Y = 16'h7FFF; OFlags = 4'b1100; FlagMask = 4'b1111; OutReady = 1'b1;
    cycle(acc);
    check("accept_7fff", {31'b0, acc}, 32'd1);
    idle_inputs();
    cycle(acc);
    check("status_1100", {28'b0, StatusFlags}, 32'h0000_000C);
    cycle(acc);

    // Fill to TWO with backpressure, third item held upstream
    OutReady = 1'b0; FlagMask = '0;
    InValid = 1'b1; Y = 16'h0001; OFlags = 4'b0001; cycle(acc);
    Y = 16'h0002; OFlags = 4'b0010; cycle(acc);
    Y = 16'h0003; OFlags = 4'b0011; cycle(acc);
    check("third_held", {31'b0, acc}, 32'd0);
    check("in_ready_low", {31'b0, InReady}, 32'd0);
    OutReady = 1'b1;
    for (int unsigned i = 0; i < 4 && !acc; i++) cycle(acc);
    check("third_taken", {31'b0, acc}, 32'd1);
    InValid = 1'b0;
    for (int unsigned i = 0; i < 4; i++) cycle(acc);
    check("fill_drained", sb_q.size(), 32'd0);

    // Masked update: only C
    FlagsLoad = 1'b1; FlagsIn = 4'b0000; cycle(acc);
    FlagsLoad = 1'b0;
    InValid = 1'b1; Y = 16'hA5A5; OFlags = 4'b1111; FlagMask = 4'b0010; cycle(acc);
    idle_inputs();
    cycle(acc);
    check("status_c_only", {28'b0, StatusFlags}, 32'h0000_0002);

    // FlagsLoad beats accept; data path still captures OFlags
    InValid = 1'b1; Y = 16'h1234; OFlags = 4'b1010; FlagMask = 4'b1111;
    FlagsLoad = 1'b1; FlagsIn = 4'b0101; cycle(acc);
    idle_inputs();
    cycle(acc);
    check("status_load", {28'b0, StatusFlags}, 32'h0000_0005);
    cycle(acc);

    // Streaming: one per cycle
    n_drained = 0;
    InValid = 1'b1; FlagMask = 4'b0001;
    for (int unsigned i = 0; i < 8; i++) begin
      Y = DW'(16'h0100 + i); OFlags = FW'(i); cycle(acc);
    end
    idle_inputs();
    cycle(acc);
    check("stream_count", n_drained, 32'd8);

    // Async reset with two entries held
    OutReady = 1'b0; FlagMask = 4'b1111;
    InValid = 1'b1; Y = 16'hBEEF; OFlags = 4'b0110; cycle(acc);
    Y = 16'hCAFE; OFlags = 4'b1001; cycle(acc);
    idle_inputs();
    cycle(acc);
    #2;
    Reset = 1'b1;
    #1;
    check("rst_out_valid", {31'b0, OutValid}, 32'd0);
    check("rst_in_ready",  {31'b0, InReady},  32'd1);
    check("rst_status",    {28'b0, StatusFlags}, 32'd0);
    check("rst_result",    {16'b0, Result}, 32'd0);
    sb_q.delete();
    exp_status = '0;
    @(negedge Clock);
    Reset = 1'b0;
    OutReady = 1'b1;
    for (int unsigned i = 0; i < 3; i++) cycle(acc);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
